// File: rtl/snoop_pkg.sv
// Shared ACE snoop-channel types: AC snoop opcodes, CR response bits and the
// AC entry buffered by the snoop front stage.
package snoop_pkg;

  localparam int unsigned AcAddrWidth = 64;

  typedef enum logic [3:0] {
    READ_ONCE             = 4'h0,
    READ_SHARED           = 4'h1,
    READ_CLEAN            = 4'h2,
    READ_NOT_SHARED_DIRTY = 4'h3,
    READ_UNIQUE           = 4'h7,
    CLEAN_SHARED          = 4'h8,
    CLEAN_INVALID         = 4'h9,
    MAKE_INVALID          = 4'hD,
    DVM_COMPLETE          = 4'hE,
    DVM_MESSAGE           = 4'hF
  } acsnoop_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic [AcAddrWidth-1:0] addr;
    acsnoop_t               snoop;
  } ac_entry_t;

endpackage

// File: rtl/snoop_ac_fifo.sv
// Generic registered FIFO; a pushed entry appears at the head on the next cycle.
// Pointers carry one extra wrap bit so full is told apart from empty.
module snoop_ac_fifo
  import snoop_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = ac_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  output logic   full_o,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   empty_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, count_q;
  entry_t          mem_q [Depth];
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snoop_ac_queue.sv
// Snoop front stage: buffers AC requests, answers non-cacheable snoops locally
// and keeps one snoop outstanding downstream. Optional counters: SNOOP_AC_QUEUE_PERF_EN.
module snoop_ac_queue
  import snoop_pkg::*;
#(
  parameter int unsigned          Depth      = 4,
  parameter int unsigned          AddrWidth  = 64,
  parameter int unsigned          LineOffset = 4,
  parameter logic [AddrWidth-1:0] CacheBase  = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] CacheMask  = 64'hFFFF_FFFF_8000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  acsnoop_t             ac_snoop_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output crresp_t              cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [63:0]          cd_data_o,
  output logic                 cd_last_o,
  output logic                 ds_ac_valid_o,
  input  logic                 ds_ac_ready_i,
  output logic [AddrWidth-1:0] ds_ac_addr_o,
  output acsnoop_t             ds_ac_snoop_o,
  input  logic                 ds_cr_valid_i,
  output logic                 ds_cr_ready_o,
  input  crresp_t              ds_cr_resp_i,
  input  logic                 ds_cd_valid_i,
  output logic                 ds_cd_ready_o,
  input  logic [63:0]          ds_cd_data_i,
  input  logic                 ds_cd_last_i,
  input  logic                 wb_pending_i,
  input  logic [AddrWidth-1:0] wb_addr_i,
  output logic                 busy_o
`ifdef SNOOP_AC_QUEUE_PERF_EN
  ,
  output logic [31:0]          perf_local_o,
  output logic [31:0]          perf_fwd_o,
  output logic [31:0]          perf_stall_o
`endif
);

  typedef enum logic [2:0] {IDLE, FWD, WAIT_DS, WAIT_CD, LOCAL_CR} state_e;

  localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << LineOffset) - 1'b1);

  state_e               state_q, state_d;
  ac_entry_t            push_entry, head;
  logic                 full, empty, pop;
  logic [AddrWidth-1:0] head_addr;
  logic                 head_cacheable, collide;

  assign push_entry.addr  = AcAddrWidth'(ac_addr_i);
  assign push_entry.snoop = ac_snoop_i;

  snoop_ac_fifo #(
    .Depth   (Depth),
    .entry_t (ac_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ac_valid_i && ac_ready_o),
    .data_i  (push_entry),
    .full_o  (full),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (empty)
  );

  assign ac_ready_o     = !full;
  assign head_addr      = AddrWidth'(head.addr);
  assign head_cacheable = ((head_addr & CacheMask) == CacheBase);
  // XOR-and-mask keeps the comparison to the line index only.
  assign collide        = wb_pending_i && (((head_addr ^ wb_addr_i) & LineMask) == '0);
  assign pop            = ((state_q == IDLE) && !empty && !head_cacheable) ||
                          ((state_q == FWD) && ds_ac_ready_i);
  assign ds_ac_addr_o   = head_addr;
  assign ds_ac_snoop_o  = head.snoop;
  assign busy_o         = !empty || (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (!head_cacheable) state_d = LOCAL_CR;
          else if (!collide)   state_d = FWD;
        end
      end
      FWD:      if (ds_ac_ready_i) state_d = WAIT_DS;
      WAIT_DS: begin
        if (ds_cr_valid_i && cr_ready_i)
          state_d = ds_cr_resp_i.data_transfer ? WAIT_CD : IDLE;
      end
      WAIT_CD:  if (ds_cd_valid_i && cd_ready_i && ds_cd_last_i) state_d = IDLE;
      LOCAL_CR: if (cr_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ds_ac_valid_o = 1'b0;
    cr_valid_o    = 1'b0;
    cr_resp_o     = '0;
    ds_cr_ready_o = 1'b0;
    cd_valid_o    = 1'b0;
    cd_data_o     = '0;
    cd_last_o     = 1'b0;
    ds_cd_ready_o = 1'b0;
    case (state_q)
      FWD: ds_ac_valid_o = 1'b1;
      WAIT_DS: begin
        cr_valid_o    = ds_cr_valid_i;
        cr_resp_o     = ds_cr_resp_i;
        ds_cr_ready_o = cr_ready_i;
        cd_valid_o    = ds_cd_valid_i;
        cd_data_o     = ds_cd_data_i;
        cd_last_o     = ds_cd_last_i;
        ds_cd_ready_o = cd_ready_i;
      end
      WAIT_CD: begin
        cd_valid_o    = ds_cd_valid_i;
        cd_data_o     = ds_cd_data_i;
        cd_last_o     = ds_cd_last_i;
        ds_cd_ready_o = cd_ready_i;
      end
      LOCAL_CR: cr_valid_o = 1'b1;
      default: ;
    endcase
  end

`ifdef SNOOP_AC_QUEUE_PERF_EN
  logic [31:0] perf_local_q, perf_fwd_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_local_q <= '0;
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q == IDLE) && pop && (perf_local_q != '1)) perf_local_q <= perf_local_q + 1'b1;
      if ((state_q == FWD) && ds_ac_ready_i && (perf_fwd_q != '1)) perf_fwd_q <= perf_fwd_q + 1'b1;
      if ((state_q == IDLE) && !empty && head_cacheable && collide && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_local_o = perf_local_q;
  assign perf_fwd_o   = perf_fwd_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: doc/snoop_ac_queue.md
Name: snoop_ac_queue

Overview:
- Front stage of the snoop path, between the ACE AC/CR/CD snoop channel from the interconnect and snoop_cache_ctrl.
- Buffers incoming AC snoop requests in a small FIFO.
- Answers snoops to non-cacheable addresses locally with a no-data CR response.
- Holds a snoop while a writeback to the same cache line is pending in the miss handler.
- Passes CR/CD responses from the cache controller back to the interconnect, keeping responses in AC order.

Parameters:
- Depth, 4: AC FIFO entries; power of two, ≥2.
- AddrWidth, 64: AC address width.
- LineOffset, 4: log2 of line bytes (16-byte line); line match compares addr[AddrWidth-1:LineOffset].
- CacheBase, 64'h8000_0000: base of the cacheable region.
- CacheMask, 64'hFFFF_FFFF_8000_0000: address is cacheable iff (addr & CacheMask) == CacheBase.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ac_valid_i  in  1  upstream AC valid
- ac_ready_o  out  1  upstream AC ready
- ac_addr_i  in  AddrWidth  snoop address
- ac_snoop_i  in  4  snoop type (snoop_pkg::acsnoop_t)
- cr_valid_o  out  1  upstream CR valid
- cr_ready_i  in  1  upstream CR ready
- cr_resp_o  out  5  upstream CR response (snoop_pkg::crresp_t)
- cd_valid_o  out  1  upstream CD valid
- cd_ready_i  in  1  upstream CD ready
- cd_data_o  out  64  upstream CD data
- cd_last_o  out  1  upstream CD last
- ds_ac_valid_o  out  1  AC valid to the cache controller
- ds_ac_ready_i  in  1  AC ready from the cache controller
- ds_ac_addr_o  out  AddrWidth  forwarded address
- ds_ac_snoop_o  out  4  forwarded snoop type
- ds_cr_valid_i  in  1  controller CR valid
- ds_cr_ready_o  out  1  controller CR ready
- ds_cr_resp_i  in  5  controller CR response
- ds_cd_valid_i  in  1  controller CD valid
- ds_cd_ready_o  out  1  controller CD ready
- ds_cd_data_i  in  64  controller CD data
- ds_cd_last_i  in  1  controller CD last
- wb_pending_i  in  1  miss handler has a writeback in flight
- wb_addr_i  in  AddrWidth  address of the in-flight writeback
- busy_o  out  1  FIFO non-empty or state ≠ IDLE

Behaviour:
- Reset: FIFO empty; state IDLE; all valid outputs 0; cr_resp_o 0; cd_data_o 0; cd_last_o 0; ac_ready_o 1 after reset; busy_o 0.
- FIFO: write pointer, read pointer and count of width $clog2(Depth)+1; pointers wrap modulo Depth.
  - ac_ready_o = !full.
  - Push on ac_valid_i && ac_ready_o.
  - Simultaneous push and pop is allowed when full, but ready stays low that cycle (no bypass of full).
  - An entry is visible at the head one cycle after its push (no fall-through).
- FSM states:
  - IDLE: if FIFO non-empty, classify the head.
    - Head not cacheable -> LOCAL_CR and pop.
    - Head cacheable and wb_pending_i with line match against wb_addr_i -> stay in IDLE (stall); re-evaluate every cycle.
    - Otherwise -> FWD.
  - FWD: ds_ac_valid_o = 1 with the head fields. On ds_ac_ready_i, pop and go to WAIT_DS. Valid is held and fields are stable until accepted.
  - WAIT_DS: ds_cr_* and ds_cd_* are combinationally connected to the upstream cr_* and cd_*; both readies pass through.
    - CR handshake with dataTransfer=0 -> IDLE.
    - CR handshake with dataTransfer=1 -> WAIT_CD.
  - WAIT_CD: CD pass-through. A CD handshake with ds_cd_last_i -> IDLE.
  - LOCAL_CR: cr_valid_o = 1 and cr_resp_o = 0. The controller CR path is not routed in this state; ds_cr_ready_o = 0. On cr_ready_i -> IDLE.
- Ordering: at most one snoop is outstanding downstream. Local responses are issued only from IDLE, so CR order always equals AC order.
- Minimum latency for a non-cacheable snoop: AC accept to cr_valid_o = 2 cycles.
- Outside the pass-through states, ds_cr_ready_o and ds_cd_ready_o are 0, and cd_valid_o/cr_valid_o are not driven from downstream.
- Reset asserted mid-transaction: every register returns to its reset value immediately; FIFO contents are discarded.

Optional Feature:
- Macro: SNOOP_AC_QUEUE_PERF_EN.
- When defined, adds three 32-bit saturating counters, each cleared on reset:
  - perf_local_o: count of local responses.
  - perf_fwd_o: count of forwarded snoops.
  - perf_stall_o: count of cycles stalled on writeback collision.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- snoop_pkg holds acsnoop_t, crresp_t and the new ac_entry_t {addr, snoop}.
- The FSM state enum stays local to the module.
- Sub-module: snoop_ac_fifo (generic FIFO, Depth, entry type ac_entry_t) provides push/pop/full/empty.

Test Plan:
- Non-cacheable snoop: ac_addr 0x1000_0000, READ_SHARED -> cr_resp 0 two cycles after accept, no ds_ac_valid, no CD.
- Cacheable hit: addr 0x8000_0040, READ_ONCE; controller returns dataTransfer=1 then two CD beats -> both beats appear upstream, cd_last on the 2nd, then IDLE.
- Collision: wb_pending_i=1, wb_addr 0x8000_0048, snoop 0x8000_0040 -> no ds_ac_valid while pending; released the cycle after wb_pending_i falls.
- Back-pressure: push 5 snoops with Depth=4 while ds_ac_ready_i=0 -> ac_ready_o low after 4 pushes, no loss, in-order forwarding after release.
- Mixed order: cacheable snoop (miss, dataTransfer=0) followed by a non-cacheable snoop -> downstream CR emitted before the local CR.
- Reset mid-WAIT_CD: assert rst_ni low -> all valids 0, busy_o 0, FIFO empty.
